// File: rtl/zxkbd_pkg.sv
// Shared constants, receiver state type and the PS/2 set-2 to ZX Spectrum matrix map.
package zxkbd_pkg;

    localparam int unsigned NumRows = 8;
    localparam int unsigned NumCols = 5;

    localparam logic [2:0] CapsRow = 3'd0;
    localparam logic [2:0] CapsCol = 3'd0;
    localparam logic [2:0] SymRow  = 3'd7;
    localparam logic [2:0] SymCol  = 3'd1;

    localparam logic [7:0] PfxExt   = 8'hE0;
    localparam logic [7:0] PfxBrk   = 8'hF0;
    localparam logic [7:0] IgnBat   = 8'hAA;
    localparam logic [7:0] IgnAck   = 8'hFA;
    localparam logic [7:0] IgnEcho  = 8'hEE;
    localparam logic [7:0] IgnResnd = 8'hFE;
    localparam logic [7:0] IgnErr0  = 8'h00;
    localparam logic [7:0] IgnErr1  = 8'hFF;

    localparam logic [7:0] CodeCtrl = 8'h14;
    localparam logic [7:0] CodeAlt  = 8'h11;
    localparam logic [7:0] CodeDel  = 8'h71;

    typedef enum logic [1:0] {StIdle, StData, StParity, StStop} rx_state_e;

    typedef enum logic [1:0] {ModNone, ModCaps, ModSym} zx_mod_e;

    typedef struct packed {
        logic       valid;
        logic [2:0] row;
        logic [2:0] col;
        zx_mod_e    mod;
    } zx_key_t;

    function automatic logic is_ignored(input logic [7:0] code);
        return code inside {IgnBat, IgnAck, IgnEcho, IgnResnd, IgnErr0, IgnErr1};
    endfunction

    function automatic zx_key_t zx_key(input logic [2:0] row, input logic [2:0] col,
                                       input zx_mod_e mod);
        zx_key_t k;
        k.valid = 1'b1;
        k.row   = row;
        k.col   = col;
        k.mod   = mod;
        return k;
    endfunction

    function automatic zx_key_t ps2_to_zx(input logic ext, input logic [7:0] code);
        zx_key_t k;
        case ({ext, code})
            9'h012, 9'h059: k = zx_key(CapsRow, CapsCol, ModNone);
            9'h01C:         k = zx_key(3'd1, 3'd0, ModNone);
            9'h01A:         k = zx_key(3'd0, 3'd1, ModNone);
            9'h015:         k = zx_key(3'd2, 3'd0, ModNone);
            9'h016:         k = zx_key(3'd3, 3'd0, ModNone);
            9'h04D:         k = zx_key(3'd5, 3'd0, ModNone);
            9'h05A:         k = zx_key(3'd6, 3'd0, ModNone);
            9'h029:         k = zx_key(3'd7, 3'd0, ModNone);
            9'h014:         k = zx_key(SymRow, SymCol, ModNone);
            9'h066:         k = zx_key(3'd4, 3'd0, ModCaps);
            9'h16B:         k = zx_key(3'd3, 3'd4, ModCaps);
            9'h174:         k = zx_key(3'd4, 3'd2, ModCaps);
            9'h175:         k = zx_key(3'd4, 3'd3, ModCaps);
            9'h172:         k = zx_key(3'd4, 3'd4, ModCaps);
            default:        k = '0;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/ps2_keyb_if.sv
// PS/2 pins plus the ULA-facing keyboard read port; the keyboard is the slave side.
interface ps2_keyb_if;
    logic       ps2clk;
    logic       ps2data;
    logic [7:0] rows;
    logic [4:0] kbcols;
    logic       kbd_reset;
    logic [7:0] scancode;
    logic       scan_valid;

    modport master (output ps2clk, ps2data, rows,
                    input  kbcols, kbd_reset, scancode, scan_valid);
    modport slave  (input  ps2clk, ps2data, rows,
                    output kbcols, kbd_reset, scancode, scan_valid);
endinterface

// File: rtl/ps2_rx.sv
// PS/2 byte receiver: pin synchronisers, clock glitch filter, frame FSM and mid-frame timeout.
module ps2_rx
    import zxkbd_pkg::*;
#(
    parameter int unsigned FILTER  = 8,
    parameter int unsigned TIMEOUT = 28000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2clk,
    input  logic       ps2data,
    output logic [7:0] data_byte,
    output logic       byte_valid,
    output logic       frame_err
);
    localparam int unsigned FiltW = (FILTER > 1) ? $clog2(FILTER) : 1;
    localparam int unsigned TmoW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [FiltW-1:0] FiltMax = FiltW'(FILTER - 1);
    localparam logic [TmoW-1:0]  TmoMax  = TmoW'(TIMEOUT - 1);

    logic [1:0]       clk_sync, dat_sync;
    logic             clk_filt;
    logic [FiltW-1:0] filt_cnt;
    logic             strobe, dbit;

    rx_state_e       state_q, state_d;
    logic [7:0]      shift_q, shift_d;
    logic [2:0]      bit_q, bit_d;
    logic            par_q, par_d;
    logic [TmoW-1:0] tmo_q, tmo_d;
    logic [7:0]      byte_d;
    logic            valid_d, err_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
            clk_filt <= 1'b1;
            filt_cnt <= '0;
        end else begin
            clk_sync <= {clk_sync[0], ps2clk};
            dat_sync <= {dat_sync[0], ps2data};
            if (clk_sync[1] == clk_filt) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FiltMax) begin
                clk_filt <= clk_sync[1];
                filt_cnt <= '0;
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end
        end
    end

    // Bit strobe is the cycle in which the filter accepts a falling edge.
    assign strobe = clk_filt && !clk_sync[1] && (filt_cnt == FiltMax);
    assign dbit   = dat_sync[1];

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        par_d   = par_q;
        tmo_d   = (state_q == StIdle || strobe) ? '0 : tmo_q + 1'b1;
        byte_d  = data_byte;
        valid_d = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            StIdle: begin
                if (strobe && !dbit) begin
                    state_d = StData;
                    bit_d   = '0;
                end
            end
            StData: begin
                if (strobe) begin
                    shift_d = {dbit, shift_q[7:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == 3'd7) state_d = StParity;
                end
            end
            StParity: begin
                if (strobe) begin
                    par_d   = dbit;
                    state_d = StStop;
                end
            end
            StStop: begin
                if (strobe) begin
                    if (dbit && ^{shift_q, par_q}) begin
                        valid_d = 1'b1;
                        byte_d  = shift_q;
                    end else begin
                        err_d = 1'b1;
                    end
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (state_q != StIdle && !strobe && tmo_q == TmoMax) begin
            state_d = StIdle;
            tmo_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            shift_q    <= '0;
            bit_q      <= '0;
            par_q      <= 1'b0;
            tmo_q      <= '0;
            data_byte  <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_q      <= bit_d;
            par_q      <= par_d;
            tmo_q      <= tmo_d;
            data_byte  <= byte_d;
            byte_valid <= valid_d;
            frame_err  <= err_d;
        end
    end
endmodule

// File: rtl/ps2_keyb.sv
// PS/2 keyboard front end: scancode decoder, ZX 8x5 key matrix, column read-out and reset combo.
module ps2_keyb
    import zxkbd_pkg::*;
#(
    parameter int unsigned FILTER  = 8,
    parameter int unsigned TIMEOUT = 28000
) (
    input logic       clk,
    input logic       rst,
    ps2_keyb_if.slave kb
);
    logic [7:0] data_byte;
    logic       byte_valid, frame_err;

    logic [NumRows-1:0][NumCols-1:0] mat_q, mat_d;
    logic    ext_q, ext_d, brk_q, brk_d;
    logic    ctrl_q, ctrl_d, alt_q, alt_d;
    logic    kres_q, kres_d;
    zx_key_t key;
    logic [NumCols-1:0] cols;

    ps2_rx #(
        .FILTER  (FILTER),
        .TIMEOUT (TIMEOUT)
    ) u_rx (
        .clk        (clk),
        .rst        (rst),
        .ps2clk     (kb.ps2clk),
        .ps2data    (kb.ps2data),
        .data_byte  (data_byte),
        .byte_valid (byte_valid),
        .frame_err  (frame_err)
    );

    always_comb begin
        mat_d  = mat_q;
        ext_d  = ext_q;
        brk_d  = brk_q;
        ctrl_d = ctrl_q;
        alt_d  = alt_q;
        kres_d = 1'b0;
        key    = ps2_to_zx(ext_q, data_byte);
        if (frame_err) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
        end else if (byte_valid) begin
            if (data_byte == PfxExt) begin
                ext_d = 1'b1;
            end else if (data_byte == PfxBrk) begin
                brk_d = 1'b1;
            end else begin
                ext_d = 1'b0;
                brk_d = 1'b0;
                if (!is_ignored(data_byte)) begin
                    // Modifier bit follows the key even if a physical Shift is still down.
                    if (key.valid) begin
                        mat_d[key.row][key.col] = !brk_q;
                        if (key.mod == ModCaps) mat_d[CapsRow][CapsCol] = !brk_q;
                        if (key.mod == ModSym)  mat_d[SymRow][SymCol]   = !brk_q;
                    end
                    if (data_byte == CodeCtrl) ctrl_d = !brk_q;
                    if (data_byte == CodeAlt)  alt_d  = !brk_q;
                    if (data_byte == CodeDel && !brk_q && ctrl_q && alt_q) kres_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mat_q  <= '0;
            ext_q  <= 1'b0;
            brk_q  <= 1'b0;
            ctrl_q <= 1'b0;
            alt_q  <= 1'b0;
            kres_q <= 1'b0;
        end else begin
            mat_q  <= mat_d;
            ext_q  <= ext_d;
            brk_q  <= brk_d;
            ctrl_q <= ctrl_d;
            alt_q  <= alt_d;
            kres_q <= kres_d;
        end
    end

    always_comb begin
        cols = '0;
        for (int r = 0; r < NumRows; r++) begin
            if (!kb.rows[r]) cols = cols | mat_q[r];
        end
    end

    assign kb.kbcols     = ~cols;
    assign kb.kbd_reset  = kres_q;
    assign kb.scancode   = data_byte;
    assign kb.scan_valid = byte_valid;
endmodule

// File: tb/tb_ps2_keyb.sv
// Directed and randomized bench for ps2_keyb against a key-table reference model.
module tb_ps2_keyb;
    localparam int unsigned FILT = 4;
    localparam int unsigned TMO  = 600;
    localparam int unsigned HALF = 20;

    logic clk = 1'b0;
    logic rst;
    ps2_keyb_if kb();

    ps2_keyb #(
        .FILTER  (FILT),
        .TIMEOUT (TMO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .kb  (kb)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int nvalid = 0;
    int nres = 0;
    int nres_exp = 0;
    logic [7:0] last_code = 8'h00;

    logic [7:0][4:0] ref_m;
    bit r_ext, r_brk, r_ctrl, r_alt;

    logic [8:0] pool [18] = '{9'h012, 9'h059, 9'h01C, 9'h01A, 9'h015, 9'h016, 9'h04D, 9'h05A,
                              9'h029, 9'h066, 9'h16B, 9'h174, 9'h175, 9'h172, 9'h03B, 9'h11C,
                              9'h014, 9'h112};

    always @(negedge clk) begin
        if (kb.scan_valid) begin
            nvalid    <= nvalid + 1;
            last_code <= kb.scancode;
        end
        if (kb.kbd_reset) nres <= nres + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Key table: primary position plus modifier (0 none, 1 CAPS at 0/0, 2 SYM at 7/1).
    function automatic bit ref_lookup(input bit e, input logic [7:0] c,
                                      output int r, output int col, output int md);
        bit hit = 1'b1;
        r = 0; col = 0; md = 0;
        if (!e) begin
            case (c)
                8'h12, 8'h59: begin r = 0; col = 0; end
                8'h1C: begin r = 1; col = 0; end
                8'h1A: begin r = 0; col = 1; end
                8'h15: begin r = 2; col = 0; end
                8'h16: begin r = 3; col = 0; end
                8'h4D: begin r = 5; col = 0; end
                8'h5A: begin r = 6; col = 0; end
                8'h29: begin r = 7; col = 0; end
                8'h14: begin r = 7; col = 1; end
                8'h66: begin r = 4; col = 0; md = 1; end
                default: hit = 1'b0;
            endcase
        end else begin
            case (c)
                8'h6B: begin r = 3; col = 4; md = 1; end
                8'h74: begin r = 4; col = 2; md = 1; end
                8'h75: begin r = 4; col = 3; md = 1; end
                8'h72: begin r = 4; col = 4; md = 1; end
                default: hit = 1'b0;
            endcase
        end
        return hit;
    endfunction

    task automatic model_byte(input logic [7:0] b);
        int r, c, md;
        if (b == 8'hE0) r_ext = 1'b1;
        else if (b == 8'hF0) r_brk = 1'b1;
        else begin
            if (!(b inside {8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF})) begin
                if (ref_lookup(r_ext, b, r, c, md)) begin
                    ref_m[r][c] = !r_brk;
                    if (md == 1) ref_m[0][0] = !r_brk;
                    if (md == 2) ref_m[7][1] = !r_brk;
                end
                if (b == 8'h14) r_ctrl = !r_brk;
                if (b == 8'h11) r_alt = !r_brk;
                if (b == 8'h71 && !r_brk && r_ctrl && r_alt) nres_exp++;
            end
            r_ext = 1'b0;
            r_brk = 1'b0;
        end
    endtask

    function automatic logic [4:0] exp_cols(input logic [7:0] rs);
        logic [4:0] v;
        v = 5'h1F;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 5; c++)
                if (!rs[r] && ref_m[r][c]) v[c] = 1'b0;
        return v;
    endfunction

    task automatic send_frame(input logic [7:0] b, input bit badpar, input int nbits);
        logic [10:0] f;
        f = {1'b1, (~^b) ^ badpar, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            kb.ps2data = f[i];
            tick(HALF);
            kb.ps2clk = 1'b0;
            tick(HALF);
            kb.ps2clk = 1'b1;
        end
        kb.ps2data = 1'b1;
        tick(HALF);
    endtask

    task automatic send(input logic [7:0] b);
        send_frame(b, 1'b0, 11);
        model_byte(b);
    endtask

    task automatic cols_at(input string tag, input logic [7:0] rs, input logic [4:0] exp);
        kb.rows = rs;
        #1;
        check(tag, kb.kbcols, exp);
        check({tag, "_model"}, kb.kbcols, exp_cols(rs));
    endtask

    task automatic model_reset();
        ref_m = '0;
        r_ext = 1'b0; r_brk = 1'b0; r_ctrl = 1'b0; r_alt = 1'b0;
    endtask

    initial begin
        int n0;
        logic [8:0] p;
        logic [7:0] rs;
        rst = 1'b1;
        kb.ps2clk = 1'b1;
        kb.ps2data = 1'b1;
        kb.rows = 8'hFF;
        model_reset();
        tick(5);
        rst = 1'b0;
        tick(2);

        check("rst_scancode", kb.scancode, 8'h00);
        check("rst_scan_valid", kb.scan_valid, 1'b0);
        check("rst_kbd_reset", kb.kbd_reset, 1'b0);
        for (int i = 0; i < 256; i++) begin
            kb.rows = i[7:0];
            tick(1);
            check("rst_cols", kb.kbcols, 5'h1F);
        end

        send(8'h1C);
        check("make_a_code", last_code, 8'h1C);
        cols_at("make_a", 8'hFD, 5'h1E);
        send(8'hF0); send(8'h1C);
        cols_at("break_a", 8'hFD, 5'h1F);

        send(8'hE0); send(8'h6B);
        cols_at("left_caps", 8'hFE, 5'h1E);
        cols_at("left_5", 8'hF7, 5'h0F);
        cols_at("left_both", 8'hF6, 5'h0E);
        send(8'hE0); send(8'hF0); send(8'h6B);
        cols_at("left_break", 8'h00, 5'h1F);

        n0 = nvalid;
        send_frame(8'h1C, 1'b1, 11);
        check("parity_no_valid", nvalid, n0);
        cols_at("parity_matrix", 8'h00, 5'h1F);
        send(8'h1A);
        cols_at("after_parity_z", 8'hFE, 5'h1D);

        send_frame(8'h05, 1'b0, 5);
        tick(TMO + 100);
        send(8'h29);
        check("timeout_code", last_code, 8'h29);
        cols_at("timeout_space", 8'h7F, 5'h1E);

        n0 = nres;
        send(8'h14); send(8'h11); send(8'hE0); send(8'h71);
        tick(2);
        check("combo_pulse", nres - n0, 1);
        send(8'hF0); send(8'h14); send(8'hE0); send(8'h71);
        tick(2);
        check("combo_no_pulse", nres - n0, 1);
        cols_at("combo_sym_clear", 8'h7F, 5'h1E);

        send(8'h16);
        cols_at("hold_1", 8'hF7, 5'h1E);
        send_frame(8'h16, 1'b0, 6);
        rst = 1'b1;
        tick(3);
        model_reset();
        cols_at("midrst_cols", 8'h00, 5'h1F);
        check("midrst_scancode", kb.scancode, 8'h00);
        rst = 1'b0;
        tick(5);
        send(8'h16);
        cols_at("after_rst_1", 8'hF7, 5'h1E);

        for (int it = 0; it < 40; it++) begin
            p = pool[$urandom_range(0, 17)];
            if (p[8]) send(8'hE0);
            if ($urandom_range(0, 1) == 1) send(8'hF0);
            if ($urandom_range(0, 7) == 0) send(8'hAA);
            send(p[7:0]);
            check("rand_code", last_code, p[7:0]);
            for (int k = 0; k < 2; k++) begin
                rs = 8'($urandom);
                kb.rows = rs;
                #1;
                check("rand_cols", kb.kbcols, exp_cols(rs));
            end
        end
        check("reset_count", nres, nres_exp);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
